completion_buffer: RTL and testbench



---
 rtl/completion_buffer.sv | 123 ++++++++++++
 tb/tb_completion_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/completion_buffer.sv
// In-order completion buffer: allocates 2/cycle at tail, marks done by tag, retires 2/cycle from head into ARF updates.
// Retire/update outputs are combinational from state; a finish at edge k can update in cycle k->k+1; a dropped allocation raises alloc_err for one cycle.
module completion_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_en_A,
    input  logic             alloc_en_B,
    input  logic             alloc_wr_A,
    input  logic             alloc_wr_B,
    input  logic [4:0]       alloc_rd_A,
    input  logic [4:0]       alloc_rd_B,
    output logic [TAG_W-1:0] alloc_tag_A,
    output logic [TAG_W-1:0] alloc_tag_B,
    output logic             alloc_ready_A,
    output logic             alloc_ready_B,
    output logic             alloc_err,
    input  logic             fin_en_A,
    input  logic             fin_en_B,
    input  logic [TAG_W-1:0] fin_tag_A,
    input  logic [TAG_W-1:0] fin_tag_B,
    output logic             retire_A,
    output logic             retire_B,
    output logic             update_en_A,
    output logic             update_en_B,
    output logic [4:0]       update_addr_A,
    output logic [4:0]       update_addr_B,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0] validQ;
    logic [DEPTH-1:0] doneQ;
    logic [DEPTH-1:0] wrQ;
    logic [4:0]       rdQ [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] headP1;
    logic [TAG_W-1:0] tagB;
    logic [TAG_W:0]   countQ;
    logic [TAG_W:0]   freeSlots;
    logic [TAG_W:0]   reqCnt;
    logic [TAG_W:0]   grantCnt;
    logic [TAG_W:0]   retCnt;
    logic             grant;
    logic             drop;
    logic             allocErrQ;

    assign headP1 = head + TAG_W'(1);
    assign tagB   = alloc_en_A ? tail + TAG_W'(1) : tail;

    // Free space is judged on the current count, before this cycle's retire.
    assign reqCnt    = (TAG_W+1)'(alloc_en_A) + (TAG_W+1)'(alloc_en_B);
    assign freeSlots = DEPTH_CNT - countQ;
    assign grant     = !flush && (reqCnt != '0) && (freeSlots >= reqCnt);
    assign drop      = !flush && (reqCnt != '0) && !grant;
    assign grantCnt  = grant ? reqCnt : '0;

    assign retire_A = !flush && validQ[head] && doneQ[head];
    assign retire_B = retire_A && validQ[headP1] && doneQ[headP1];
    assign retCnt   = (TAG_W+1)'(retire_A) + (TAG_W+1)'(retire_B);

    assign update_en_A   = retire_A && wrQ[head];
    assign update_en_B   = retire_B && wrQ[headP1];
    assign update_addr_A = retire_A ? rdQ[head] : 5'd0;
    assign update_addr_B = retire_B ? rdQ[headP1] : 5'd0;

    assign alloc_tag_A   = tail;
    assign alloc_tag_B   = tagB;
    assign alloc_ready_A = !flush && (countQ < DEPTH_CNT);
    assign alloc_ready_B = !flush && (countQ <= DEPTH_CNT - (TAG_W+1)'(2));
    assign alloc_err     = allocErrQ;
    assign count         = countQ;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            validQ    <= '0;
            doneQ     <= '0;
            head      <= '0;
            tail      <= '0;
            countQ    <= '0;
            allocErrQ <= 1'b0;
        end else begin
            allocErrQ <= drop;
            countQ    <= countQ + grantCnt - retCnt;
            head      <= head + retCnt[TAG_W-1:0];

            if (fin_en_A && validQ[fin_tag_A]) doneQ[fin_tag_A] <= 1'b1;
            if (fin_en_B && validQ[fin_tag_B]) doneQ[fin_tag_B] <= 1'b1;

            // Later assignments win: a retiring entry is cleared even if finished again.
            if (retire_A) begin
                validQ[head] <= 1'b0;
                doneQ[head]  <= 1'b0;
            end
            if (retire_B) begin
                validQ[headP1] <= 1'b0;
                doneQ[headP1]  <= 1'b0;
            end

            if (grant) begin
                tail <= tail + grantCnt[TAG_W-1:0];
                if (alloc_en_A) begin
                    validQ[tail] <= 1'b1;
                    doneQ[tail]  <= 1'b0;
                    wrQ[tail]    <= alloc_wr_A;
                    rdQ[tail]    <= alloc_rd_A;
                end
                if (alloc_en_B) begin
                    validQ[tagB] <= 1'b1;
                    doneQ[tagB]  <= 1'b0;
                    wrQ[tagB]    <= alloc_wr_B;
                    rdQ[tagB]    <= alloc_rd_B;
                end
            end
        end
    end

endmodule

// File: tb/tb_completion_buffer.sv
// Directed bench for completion_buffer: reset, pairing, out-of-order finish, full, wrap, flush, mid-stream reset.
module tb_completion_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       alloc_en_A, alloc_en_B, alloc_wr_A, alloc_wr_B;
    logic [4:0] alloc_rd_A, alloc_rd_B;
    logic [2:0] alloc_tag_A, alloc_tag_B;
    logic       alloc_ready_A, alloc_ready_B, alloc_err;
    logic       fin_en_A, fin_en_B;
    logic [2:0] fin_tag_A, fin_tag_B;
    logic       retire_A, retire_B, update_en_A, update_en_B;
    logic [4:0] update_addr_A, update_addr_B;
    logic [3:0] count;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    completion_buffer #(.DEPTH(8), .TAG_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_en_A(alloc_en_A), .alloc_en_B(alloc_en_B),
        .alloc_wr_A(alloc_wr_A), .alloc_wr_B(alloc_wr_B),
        .alloc_rd_A(alloc_rd_A), .alloc_rd_B(alloc_rd_B),
        .alloc_tag_A(alloc_tag_A), .alloc_tag_B(alloc_tag_B),
        .alloc_ready_A(alloc_ready_A), .alloc_ready_B(alloc_ready_B),
        .alloc_err(alloc_err),
        .fin_en_A(fin_en_A), .fin_en_B(fin_en_B),
        .fin_tag_A(fin_tag_A), .fin_tag_B(fin_tag_B),
        .retire_A(retire_A), .retire_B(retire_B),
        .update_en_A(update_en_A), .update_en_B(update_en_B),
        .update_addr_A(update_addr_A), .update_addr_B(update_addr_B),
        .count(count)
    );

    task automatic idle;
        flush = 0;
        alloc_en_A = 0; alloc_en_B = 0; alloc_wr_A = 0; alloc_wr_B = 0;
        alloc_rd_A = 0; alloc_rd_B = 0;
        fin_en_A = 0; fin_en_B = 0; fin_tag_A = 0; fin_tag_B = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc2(input logic [4:0] rdA, input logic wrA, input logic [4:0] rdB, input logic wrB);
        alloc_en_A = 1; alloc_wr_A = wrA; alloc_rd_A = rdA;
        alloc_en_B = 1; alloc_wr_B = wrB; alloc_rd_B = rdB;
        tick();
    endtask

    task automatic do_reset;
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        nChecks++; if (count !== 4'd0) begin nFails++; $display("FAIL reset_count got %0d want 0", count); end
        nChecks++; if ({alloc_ready_A, alloc_ready_B} !== 2'b11) begin nFails++; $display("FAIL reset_ready got %b want 11", {alloc_ready_A, alloc_ready_B}); end
        nChecks++; if ({alloc_tag_A, alloc_tag_B} !== 6'd0) begin nFails++; $display("FAIL reset_tags got %0d/%0d want 0/0", alloc_tag_A, alloc_tag_B); end
        nChecks++; if ({retire_A, retire_B, update_en_A, update_en_B, alloc_err} !== 5'd0) begin nFails++; $display("FAIL reset_outs got %b want 00000", {retire_A, retire_B, update_en_A, update_en_B, alloc_err}); end
        nChecks++; if ({update_addr_A, update_addr_B} !== 10'd0) begin nFails++; $display("FAIL reset_addr got %0d/%0d want 0/0", update_addr_A, update_addr_B); end
    endtask

    task automatic test_basic_pair;
        do_reset();
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 5;
        alloc_en_B = 1; alloc_wr_B = 1; alloc_rd_B = 9;
        #1;
        nChecks++; if ({alloc_tag_A, alloc_tag_B} !== {3'd0, 3'd1}) begin nFails++; $display("FAIL basic_tags got %0d/%0d want 0/1", alloc_tag_A, alloc_tag_B); end
        tick();
        nChecks++; if (count !== 4'd2) begin nFails++; $display("FAIL basic_count got %0d want 2", count); end
        fin_en_A = 1; fin_tag_A = 0; fin_en_B = 1; fin_tag_B = 1;
        #1;
        nChecks++; if (retire_A !== 1'b0) begin nFails++; $display("FAIL basic_no_early_retire got %b want 0", retire_A); end
        tick();
        #1;
        nChecks++; if ({update_en_A, update_en_B} !== 2'b11) begin nFails++; $display("FAIL basic_upd_en got %b want 11", {update_en_A, update_en_B}); end
        nChecks++; if (update_addr_A !== 5'd5 || update_addr_B !== 5'd9) begin nFails++; $display("FAIL basic_upd_addr got %0d/%0d want 5/9", update_addr_A, update_addr_B); end
        tick();
        #1;
        nChecks++; if (count !== 4'd0 || update_en_A !== 1'b0) begin nFails++; $display("FAIL basic_drain got count %0d upd %b want 0/0", count, update_en_A); end
    endtask

    task automatic test_out_of_order;
        do_reset();
        alloc2(5'd1, 1'b1, 5'd2, 1'b1);
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 3;
        #1;
        nChecks++; if (alloc_tag_A !== 3'd2) begin nFails++; $display("FAIL ooo_tag got %0d want 2", alloc_tag_A); end
        tick();
        fin_en_A = 1; fin_tag_A = 2; fin_en_B = 1; fin_tag_B = 2;
        tick();
        fin_en_A = 1; fin_tag_A = 1;
        tick();
        #1;
        nChecks++; if (retire_A !== 1'b0 || count !== 4'd3) begin nFails++; $display("FAIL ooo_hold got retire %b count %0d want 0/3", retire_A, count); end
        fin_en_B = 1; fin_tag_B = 0;
        tick();
        #1;
        nChecks++; if ({retire_A, retire_B} !== 2'b11 || update_addr_A !== 5'd1 || update_addr_B !== 5'd2) begin nFails++; $display("FAIL ooo_pop01 got %b addr %0d/%0d want 11 1/2", {retire_A, retire_B}, update_addr_A, update_addr_B); end
        tick();
        #1;
        nChecks++; if ({retire_A, retire_B} !== 2'b10 || update_addr_A !== 5'd3) begin nFails++; $display("FAIL ooo_pop2 got %b addr %0d want 10 3", {retire_A, retire_B}, update_addr_A); end
        tick();
        #1;
        nChecks++; if (count !== 4'd0) begin nFails++; $display("FAIL ooo_empty got %0d want 0", count); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 4; i++) alloc2(5'(2*i), 1'b1, 5'(2*i+1), 1'b1);
        #1;
        nChecks++; if (count !== 4'd8 || alloc_ready_A !== 1'b0 || alloc_ready_B !== 1'b0) begin nFails++; $display("FAIL full_state got count %0d rdy %b%b want 8 00", count, alloc_ready_A, alloc_ready_B); end
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 20;
        tick();
        #1;
        nChecks++; if (alloc_err !== 1'b1 || count !== 4'd8) begin nFails++; $display("FAIL full_drop got err %b count %0d want 1/8", alloc_err, count); end
        fin_en_A = 1; fin_tag_A = 0; fin_en_B = 1; fin_tag_B = 1;
        tick();
        #1;
        nChecks++; if (alloc_err !== 1'b0) begin nFails++; $display("FAIL full_err_pulse got %b want 0", alloc_err); end
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 21;
        #1;
        nChecks++; if ({retire_A, retire_B} !== 2'b11) begin nFails++; $display("FAIL full_retire got %b want 11", {retire_A, retire_B}); end
        tick();
        #1;
        nChecks++; if (alloc_err !== 1'b1 || count !== 4'd6) begin nFails++; $display("FAIL full_retire_drop got err %b count %0d want 1/6", alloc_err, count); end
        nChecks++; if (alloc_ready_B !== 1'b1) begin nFails++; $display("FAIL full_ready_b got %b want 1", alloc_ready_B); end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 3; i++) alloc2(5'd1, 1'b1, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            fin_en_A = 1; fin_tag_A = 3'(2*i); fin_en_B = 1; fin_tag_B = 3'(2*i+1);
            tick();
        end
        tick();
        #1;
        nChecks++; if (count !== 4'd0 || alloc_tag_A !== 3'd6) begin nFails++; $display("FAIL wrap_head6 got count %0d tail %0d want 0/6", count, alloc_tag_A); end
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 10;
        alloc_en_B = 1; alloc_wr_B = 0; alloc_rd_B = 11;
        #1;
        nChecks++; if ({alloc_tag_A, alloc_tag_B} !== {3'd6, 3'd7}) begin nFails++; $display("FAIL wrap_tags67 got %0d/%0d want 6/7", alloc_tag_A, alloc_tag_B); end
        tick();
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 12;
        alloc_en_B = 1; alloc_wr_B = 1; alloc_rd_B = 13;
        #1;
        nChecks++; if ({alloc_tag_A, alloc_tag_B} !== {3'd0, 3'd1}) begin nFails++; $display("FAIL wrap_tags01 got %0d/%0d want 0/1", alloc_tag_A, alloc_tag_B); end
        tick();
        fin_en_A = 1; fin_tag_A = 6; fin_en_B = 1; fin_tag_B = 7;
        tick();
        fin_en_A = 1; fin_tag_A = 0; fin_en_B = 1; fin_tag_B = 1;
        #1;
        nChecks++; if ({retire_A, retire_B, update_en_A, update_en_B} !== 4'b1110 || update_addr_A !== 5'd10) begin nFails++; $display("FAIL wrap_pop67 got %b addr %0d want 1110 10", {retire_A, retire_B, update_en_A, update_en_B}, update_addr_A); end
        tick();
        #1;
        nChecks++; if ({update_en_A, update_en_B} !== 2'b11 || update_addr_A !== 5'd12 || update_addr_B !== 5'd13) begin nFails++; $display("FAIL wrap_pop01 got %b addr %0d/%0d want 11 12/13", {update_en_A, update_en_B}, update_addr_A, update_addr_B); end
        tick();
        alloc_en_B = 1; alloc_wr_B = 1; alloc_rd_B = 14;
        #1;
        nChecks++; if (count !== 4'd0 || alloc_tag_B !== 3'd2) begin nFails++; $display("FAIL wrap_b_only got count %0d tagB %0d want 0/2", count, alloc_tag_B); end
        tick();
        #1;
        nChecks++; if (count !== 4'd1 || alloc_tag_A !== 3'd3) begin nFails++; $display("FAIL wrap_b_alloc got count %0d tail %0d want 1/3", count, alloc_tag_A); end
    endtask

    task automatic test_flush;
        do_reset();
        alloc2(5'd4, 1'b1, 5'd5, 1'b1);
        alloc2(5'd6, 1'b1, 5'd7, 1'b1);
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 8;
        tick();
        fin_en_A = 1; fin_tag_A = 0;
        tick();
        #1;
        nChecks++; if (retire_A !== 1'b1 || count !== 4'd5) begin nFails++; $display("FAIL flush_pre got retire %b count %0d want 1/5", retire_A, count); end
        flush = 1; alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 9;
        #1;
        nChecks++; if ({retire_A, update_en_A, alloc_ready_A, alloc_ready_B} !== 4'b0000) begin nFails++; $display("FAIL flush_gate got %b want 0000", {retire_A, update_en_A, alloc_ready_A, alloc_ready_B}); end
        tick();
        #1;
        nChecks++; if (count !== 4'd0 || alloc_tag_A !== 3'd0 || alloc_err !== 1'b0) begin nFails++; $display("FAIL flush_after got count %0d tail %0d err %b want 0/0/0", count, alloc_tag_A, alloc_err); end
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 17;
        tick();
        fin_en_A = 1; fin_tag_A = 0;
        tick();
        #1;
        nChecks++; if (retire_A !== 1'b1 || update_addr_A !== 5'd17) begin nFails++; $display("FAIL flush_head0 got retire %b addr %0d want 1/17", retire_A, update_addr_A); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        alloc2(5'd21, 1'b1, 5'd22, 1'b1);
        alloc_en_A = 1; alloc_wr_A = 1; alloc_rd_A = 23;
        tick();
        fin_en_A = 1; fin_tag_A = 0; fin_en_B = 1; fin_tag_B = 1;
        tick();
        fin_en_A = 1; fin_tag_A = 2;
        rst = 1;
        tick();
        rst = 0;
        #1;
        nChecks++; if (count !== 4'd0 || {alloc_ready_A, alloc_ready_B} !== 2'b11) begin nFails++; $display("FAIL rstmid_count got %0d rdy %b%b want 0 11", count, alloc_ready_A, alloc_ready_B); end
        nChecks++; if ({retire_A, retire_B, update_en_A, update_en_B, alloc_err} !== 5'd0 || update_addr_A !== 5'd0) begin nFails++; $display("FAIL rstmid_outs got %b addr %0d want 00000 0", {retire_A, retire_B, update_en_A, update_en_B, alloc_err}, update_addr_A); end
        nChecks++; if ({alloc_tag_A, alloc_tag_B} !== 6'd0) begin nFails++; $display("FAIL rstmid_tags got %0d/%0d want 0/0", alloc_tag_A, alloc_tag_B); end
        tick();
        #1;
        nChecks++; if (update_en_A !== 1'b0 || count !== 4'd0) begin nFails++; $display("FAIL rstmid_quiet got upd %b count %0d want 0/0", update_en_A, count); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_basic_pair();
        test_out_of_order();
        test_full();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
